bram_arbiter: RTL and testbench

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arbiter.sv | 123 ++++++++++++
 tb/tb_bram_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// Two-port round-robin arbiter (CPU read/write, video read-only) in front of one block RAM.
// Ack arrives two cycles after the granting edge; a waiting port simply holds req until IDLE.
module bram_arbiter #(
    parameter logic [15:0] MEM_TOP = 16'hEFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_ack,
    output logic        a_err,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic [15:0] b_addr,
    output logic        b_ack,
    output logic [15:0] b_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_cs_n,
    output logic        mem_wr_n,
    output logic        mem_rd_n,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t      state;
    logic        last_b;
    logic        gnt_b;
    logic        lat_we;
    logic        lat_oor;

    logic        a_elig;
    logic        b_elig;
    logic        pick_b;
    logic [15:0] sel_addr;
    logic        sel_we;
    logic        sel_oor;
    logic [15:0] resp_dat;

    // A port that is being acked this cycle is not eligible, which is what
    // makes a continuously requesting pair alternate instead of double-granting.
    assign a_elig   = a_req & ~a_ack;
    assign b_elig   = b_req & ~b_ack;
    assign pick_b   = b_elig & (~a_elig | ~last_b);
    assign sel_addr = pick_b ? b_addr : a_addr;
    assign sel_we   = ~pick_b & a_we;
    assign sel_oor  = (sel_addr > MEM_TOP);
    assign resp_dat = (lat_we | lat_oor) ? 16'h0000 : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            gnt_b     <= 1'b0;
            lat_we    <= 1'b0;
            lat_oor   <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            mem_cs_n  <= 1'b1;
            mem_wr_n  <= 1'b1;
            mem_rd_n  <= 1'b1;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_err     <= 1'b0;
            a_rdata   <= 16'h0000;
            b_rdata   <= 16'h0000;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            a_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_elig | b_elig) begin
                        gnt_b    <= pick_b;
                        last_b   <= pick_b;
                        mem_addr <= sel_addr;
                        if (!pick_b) begin
                            mem_wdata <= a_wdata;
                        end
                        lat_we   <= sel_we;
                        lat_oor  <= sel_oor;
                        // Strobes are set here so they are registered and live only in ACCESS.
                        mem_cs_n <= sel_oor;
                        mem_wr_n <= sel_oor | ~sel_we;
                        mem_rd_n <= sel_oor | sel_we;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_cs_n <= 1'b1;
                    mem_wr_n <= 1'b1;
                    mem_rd_n <= 1'b1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (gnt_b) begin
                        b_ack   <= 1'b1;
                        b_rdata <= resp_dat;
                    end else begin
                        a_ack   <= 1'b1;
                        a_rdata <= resp_dat;
                        a_err   <= lat_oor;
                    end
                    state <= IDLE;
                end
                default: begin
                    mem_cs_n <= 1'b1;
                    mem_wr_n <= 1'b1;
                    mem_rd_n <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: vector table of single-port accesses plus
// hand-written tie, alternation and reset-abort sequences against a block RAM model.
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0;
    logic        a_we = 1'b0;
    logic [15:0] a_addr = 16'h0000;
    logic [15:0] a_wdata = 16'h0000;
    logic        a_ack;
    logic        a_err;
    logic [15:0] a_rdata;
    logic        b_req = 1'b0;
    logic [15:0] b_addr = 16'h0000;
    logic        b_ack;
    logic [15:0] b_rdata;
    logic [15:0] mem_addr;
    logic        mem_cs_n;
    logic        mem_wr_n;
    logic        mem_rd_n;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;

    int total = 0;
    int bad = 0;

    logic [15:0] ram [0:65535];
    logic        ram_ready = 1'b0;

    bram_arbiter #(.MEM_TOP(16'hEFFF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_err     (a_err),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .mem_addr  (mem_addr),
        .mem_cs_n  (mem_cs_n),
        .mem_wr_n  (mem_wr_n),
        .mem_rd_n  (mem_rd_n),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Block RAM model: preloaded with addr ^ 0x5A5A, registered read data.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 65536; i++) ram[i] = 16'(i) ^ 16'h5A5A;
            ram_ready = 1'b1;
        end
        if (!mem_cs_n) begin
            if (!mem_wr_n) ram[mem_addr] = mem_wdata;
            if (!mem_rd_n) mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic        port_b;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_cs;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int cs_cnt = 0;
        int wr_cnt = 0;
        int rd_cnt = 0;
        int lat = 0;
        logic [15:0] got = 16'h0000;
        logic        got_err = 1'b0;
        @(negedge clk);
        if (v.port_b) begin
            b_req  = 1'b1;
            b_addr = v.addr;
        end else begin
            a_req   = 1'b1;
            a_we    = v.we;
            a_addr  = v.addr;
            a_wdata = v.wdata;
        end
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge clk);
            if (!mem_cs_n) cs_cnt++;
            if (!mem_wr_n) wr_cnt++;
            if (!mem_rd_n) rd_cnt++;
            if (v.port_b ? b_ack : a_ack) begin
                lat     = c;
                got     = v.port_b ? b_rdata : a_rdata;
                got_err = a_err;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        if (lat == 0) begin
            total++;
            bad++;
            $display("FAIL vec%0d_timeout: got no ack want ack within 12 cycles", idx);
        end else begin
            check($sformatf("vec%0d_latency", idx), lat, 3);
            check($sformatf("vec%0d_cs_cycles", idx), cs_cnt, v.exp_cs);
            check($sformatf("vec%0d_wr_cycles", idx), wr_cnt, v.exp_wr);
            check($sformatf("vec%0d_rd_cycles", idx), rd_cnt, v.exp_rd);
            check($sformatf("vec%0d_rdata", idx), got, v.exp_rdata);
            check($sformatf("vec%0d_err", idx), got_err, v.exp_err);
        end
        @(negedge clk);
        check($sformatf("vec%0d_ack_pulse", idx), v.port_b ? b_ack : a_ack, 1'b0);
        check($sformatf("vec%0d_err_idle", idx), a_err, 1'b0);
        check($sformatf("vec%0d_rdata_hold", idx), v.port_b ? b_rdata : a_rdata, v.exp_rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ac;
        int bc;
        int n;
        vec_t rv;

        //          port  we    addr      wdata     rdata     err   cs wr rd
        vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0, 1, 1, 0};
        vecs[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 1, 0, 1};
        vecs[2] = '{1'b0, 1'b0, 16'hF000, 16'h0000, 16'h0000, 1'b1, 0, 0, 0};
        vecs[3] = '{1'b0, 1'b0, 16'hEFFF, 16'h0000, 16'hB5A5, 1'b0, 1, 0, 1};
        vecs[4] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 1, 0, 1};
        vecs[5] = '{1'b0, 1'b1, 16'hF000, 16'hDEAD, 16'h0000, 1'b1, 0, 0, 0};
        vecs[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 0, 0, 0};
        vecs[7] = '{1'b0, 1'b1, 16'h0020, 16'hCAFE, 16'h0000, 1'b0, 1, 1, 0};
        vecs[8] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hCAFE, 1'b0, 1, 0, 1};
        vecs[9] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 16'h5A5B, 1'b0, 1, 0, 1};

        // Reset values while held in reset with a request pending.
        a_req = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", mem_cs_n, 1'b1);
        check("rst_wr_n", mem_wr_n, 1'b1);
        check("rst_rd_n", mem_rd_n, 1'b1);
        check("rst_acks", {a_ack, b_ack, a_err}, 3'b000);
        check("rst_rdata", {a_rdata, b_rdata}, 32'h0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        a_req = 1'b0;
        rst_n = 1'b1;

        // Simultaneous requests straight after reset: A wins, B follows 3 cycles later.
        ac = 0;
        bc = 0;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0001;
        b_req = 1'b1; b_addr = 16'h0002;
        for (int c = 1; c <= 15 && (ac == 0 || bc == 0); c++) begin
            @(negedge clk);
            check("tie_dual_ack", a_ack & b_ack, 1'b0);
            if (a_ack && ac == 0) begin
                ac = c;
                a_req = 1'b0;
                check("tie_a_rdata", a_rdata, 16'h5A5B);
            end
            if (b_ack && bc == 0) begin
                bc = c;
                b_req = 1'b0;
                check("tie_b_rdata", b_rdata, 16'h5A58);
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("tie_a_latency", ac, 3);
        check("tie_b_latency", bc, 6);
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

        // Continuous requests from both ports after a fresh reset: strict A,B alternation.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
        b_req = 1'b1; b_addr = 16'h0020;
        n = 0;
        for (int c = 1; c <= 40 && n < 6; c++) begin
            @(negedge clk);
            check("alt_dual_ack", a_ack & b_ack, 1'b0);
            if (a_ack || b_ack) begin
                check($sformatf("alt%0d_port_b", n), b_ack, n[0]);
                check($sformatf("alt%0d_cycle", n), c, 3 * (n + 1));
                check($sformatf("alt%0d_rdata", n), b_ack ? b_rdata : a_rdata,
                      n[0] ? 16'hCAFE : 16'h1234);
                n++;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("alt_count", n, 6);
        repeat (4) @(negedge clk);

        // Reset pulse in the middle of the ACCESS cycle of a write.
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0030; a_wdata = 16'hBEEF;
        @(posedge clk);
        #2;
        check("abort_cs_active", {mem_cs_n, mem_wr_n}, 2'b00);
        #1;
        rst_n = 1'b0;
        a_req = 1'b0;
        #1;
        check("abort_cs_async", mem_cs_n, 1'b1);
        check("abort_wr_async", mem_wr_n, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_ack_rst", a_ack, 1'b0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_no_ack", a_ack, 1'b0);
            check("abort_idle_cs", mem_cs_n, 1'b1);
        end
        check("abort_ram_word", ram[16'h0030], 16'h5A6A);
        rv = '{1'b0, 1'b0, 16'h0030, 16'h0000, 16'h5A6A, 1'b0, 1, 0, 1};
        run_txn(rv, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
